// File: rtl/uart_bus_master_if.sv
// User-side transmit/receive handshake plus the register bus to the UART peripheral.
// The master modport is the bus master's view; slave is the peripheral/user side.
interface uart_bus_master_if;
   logic        tx_req_i;
   logic [7:0]  tx_byte_i;
   logic        tx_rdy_o;
   logic        tx_done_o;
   logic        tx_err_o;
   logic        rx_valid_o;
   logic [7:0]  rx_byte_o;
   logic        wr_o;
   logic        reg_sel_o;
   logic        addr_o;
   logic [31:0] wdata_o;
   logic [31:0] rdata_i;

   modport master (
      input  tx_req_i, tx_byte_i, rdata_i,
      output tx_rdy_o, tx_done_o, tx_err_o, rx_valid_o, rx_byte_o,
             wr_o, reg_sel_o, addr_o, wdata_o
   );

   modport slave (
      output tx_req_i, tx_byte_i, rdata_i,
      input  tx_rdy_o, tx_done_o, tx_err_o, rx_valid_o, rx_byte_o,
             wr_o, reg_sel_o, addr_o, wdata_o
   );
endinterface

// File: rtl/uart_bus_master.sv
// Polls a UART peripheral's control register, drains received bytes and pushes
// single user bytes out, aborting a transmit that stays busy too long.
module uart_bus_master #(
   parameter int TIMEOUT_CYC = 200000
) (
   input logic               clk,
   input logic               rst,
   uart_bus_master_if.master bus
);

   localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE, RX_READ, RX_CLR, TX_DATA, TX_CTRL, TX_WAIT
   } state_t;

   state_t           state_q, state_d;
   logic             pending_q;
   logic [7:0]       byte_q;
   logic [CNT_W-1:0] cnt_q;
   logic             tx_rdy_q, tx_done_q, tx_err_q;
   logic [7:0]       rx_byte_q;

   logic             wr, reg_sel, addr, rx_valid;
   logic [31:0]      wdata;
   logic             done_set, err_set, cnt_clr, rx_cap, accept;
   logic             unused_rdata;

   assign accept       = bus.tx_req_i & tx_rdy_q;
   assign unused_rdata = ^bus.rdata_i[31:8];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         cnt_q     <= '0;
         tx_rdy_q  <= 1'b1;
         tx_done_q <= 1'b0;
         tx_err_q  <= 1'b0;
         rx_byte_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         tx_done_q <= done_set;
         tx_err_q  <= err_set;
         if (done_set || err_set)
            pending_q <= 1'b0;
         else if (accept)
            pending_q <= 1'b1;
         // Ready drops right after accept and returns one cycle after the completion pulse.
         if (accept)
            tx_rdy_q <= 1'b0;
         else if (tx_done_q || tx_err_q)
            tx_rdy_q <= 1'b1;
         if (cnt_clr)
            cnt_q <= '0;
         else if (state_q == TX_WAIT && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
         if (rx_cap)
            rx_byte_q <= bus.rdata_i[7:0];
      end
   end

   // Payload only; meaningful solely while pending_q is set.
   always_ff @(posedge clk) begin
      if (accept)
         byte_q <= bus.tx_byte_i;
   end

   always_comb begin
      state_d  = state_q;
      wr       = 1'b0;
      reg_sel  = 1'b0;
      addr     = 1'b0;
      wdata    = 32'h0;
      rx_valid = 1'b0;
      done_set = 1'b0;
      err_set  = 1'b0;
      cnt_clr  = 1'b0;
      rx_cap   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.rdata_i[1])
               state_d = RX_READ;
            else if (pending_q && !bus.rdata_i[0])
               state_d = TX_DATA;
         end
         RX_READ: begin
            reg_sel = 1'b1;
            addr    = 1'b1;
            rx_cap  = 1'b1;
            state_d = RX_CLR;
         end
         RX_CLR: begin
            wr       = 1'b1;
            rx_valid = 1'b1;
            state_d  = IDLE;
         end
         TX_DATA: begin
            wr      = 1'b1;
            reg_sel = 1'b1;
            wdata   = {24'h0, byte_q};
            state_d = TX_CTRL;
         end
         TX_CTRL: begin
            wr      = 1'b1;
            wdata   = 32'h1;
            cnt_clr = 1'b1;
            state_d = TX_WAIT;
         end
         TX_WAIT: begin
            if (!bus.rdata_i[0]) begin
               done_set = 1'b1;
               state_d  = IDLE;
            end else if (cnt_q >= CNT_LAST) begin
               err_set = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.wr_o       = wr;
   assign bus.reg_sel_o  = reg_sel;
   assign bus.addr_o     = addr;
   assign bus.wdata_o    = wdata;
   assign bus.rx_valid_o = rx_valid;
   assign bus.rx_byte_o  = rx_byte_q;
   assign bus.tx_rdy_o   = tx_rdy_q;
   assign bus.tx_done_o  = tx_done_q;
   assign bus.tx_err_o   = tx_err_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: transmit, receive, priority, timeout and reset abort.
module tb_uart_bus_master;
   logic        clk;
   logic        rst;
   logic [31:0] ctrl_reg;
   logic [7:0]  rx_data;
   int          nasrt = 0;
   int          nfail = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          valid_cnt = 0;
   int          d0, e0, v0;

   uart_bus_master_if bif ();

   uart_bus_master #(.TIMEOUT_CYC(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.master)
   );

   // Peripheral register file seen combinationally through the bus select lines.
   assign bif.rdata_i = bif.reg_sel_o ? (bif.addr_o ? {24'h0, rx_data} : 32'h0) : ctrl_reg;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bif.tx_done_o)  done_cnt  <= done_cnt + 1;
      if (bif.tx_err_o)   err_cnt   <= err_cnt + 1;
      if (bif.rx_valid_o) valid_cnt <= valid_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nasrt++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_bus(input string tag, input logic wr, input logic sel,
                            input logic ad, input logic [31:0] wd);
      check({tag, ".wr"},      {31'h0, bif.wr_o},      {31'h0, wr});
      check({tag, ".reg_sel"}, {31'h0, bif.reg_sel_o}, {31'h0, sel});
      check({tag, ".addr"},    {31'h0, bif.addr_o},    {31'h0, ad});
      check({tag, ".wdata"},   bif.wdata_o,            wd);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".tx_rdy"},   {31'h0, bif.tx_rdy_o},   32'h1);
      check({tag, ".tx_done"},  {31'h0, bif.tx_done_o},  32'h0);
      check({tag, ".tx_err"},   {31'h0, bif.tx_err_o},   32'h0);
      check({tag, ".rx_valid"}, {31'h0, bif.rx_valid_o}, 32'h0);
      check({tag, ".rx_byte"},  {24'h0, bif.rx_byte_o},  32'h0);
      check_bus(tag, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b0;
      bif.tx_req_i  = 1'b0;
      bif.tx_byte_i = 8'h00;
      ctrl_reg = 32'h0;
      rx_data  = 8'h00;

      // Reset state
      tick();
      check_reset_outputs("rst");
      rst = 1'b1;
      tick();
      check_bus("idle", 1'b0, 1'b0, 1'b0, 32'h0);

      // Transmit 0xA5, peripheral busy for 10 cycles
      d0 = done_cnt; e0 = err_cnt;
      bif.tx_req_i = 1'b1; bif.tx_byte_i = 8'hA5;
      tick();
      bif.tx_req_i = 1'b0;
      check("tx.rdy_low", {31'h0, bif.tx_rdy_o}, 32'h0);
      check_bus("tx.idle", 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      check_bus("tx.data", 1'b1, 1'b1, 1'b0, 32'hA5);
      tick();
      check_bus("tx.ctrl", 1'b1, 1'b0, 1'b0, 32'h1);
      ctrl_reg = 32'h1;
      tick();
      check_bus("tx.wait", 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++) tick();
      check("tx.no_early_done", done_cnt - d0, 0);
      check("tx.busy_rdy", {31'h0, bif.tx_rdy_o}, 32'h0);
      ctrl_reg = 32'h0;
      tick();
      check("tx.done_pulse", {31'h0, bif.tx_done_o}, 32'h1);
      check("tx.rdy_still_low", {31'h0, bif.tx_rdy_o}, 32'h0);
      tick();
      check("tx.done_end", {31'h0, bif.tx_done_o}, 32'h0);
      check("tx.rdy_high", {31'h0, bif.tx_rdy_o}, 32'h1);
      check("tx.done_count", done_cnt - d0, 1);
      check("tx.err_count", err_cnt - e0, 0);

      // Receive 0x3C
      v0 = valid_cnt;
      rx_data = 8'h3C; ctrl_reg = 32'h2;
      tick();
      check_bus("rx.read", 1'b0, 1'b1, 1'b1, 32'h0);
      tick();
      check_bus("rx.clr", 1'b1, 1'b0, 1'b0, 32'h0);
      check("rx.valid", {31'h0, bif.rx_valid_o}, 32'h1);
      check("rx.byte", {24'h0, bif.rx_byte_o}, 32'h3C);
      ctrl_reg = 32'h0;
      tick();
      check("rx.valid_end", {31'h0, bif.rx_valid_o}, 32'h0);
      check("rx.byte_held", {24'h0, bif.rx_byte_o}, 32'h3C);
      check("rx.valid_count", valid_cnt - v0, 1);

      // Receive wins over a pending transmit
      d0 = done_cnt;
      bif.tx_req_i = 1'b1; bif.tx_byte_i = 8'h5A;
      tick();
      bif.tx_req_i = 1'b0;
      rx_data = 8'hC3; ctrl_reg = 32'h2;
      tick();
      check_bus("pri.rx_read", 1'b0, 1'b1, 1'b1, 32'h0);
      tick();
      check_bus("pri.rx_clr", 1'b1, 1'b0, 1'b0, 32'h0);
      check("pri.rx_byte", {24'h0, bif.rx_byte_o}, 32'hC3);
      ctrl_reg = 32'h0;
      tick();
      check_bus("pri.idle", 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      check_bus("pri.tx_data", 1'b1, 1'b1, 1'b0, 32'h5A);
      tick();
      check_bus("pri.tx_ctrl", 1'b1, 1'b0, 1'b0, 32'h1);
      tick();
      tick();
      check("pri.done_pulse", {31'h0, bif.tx_done_o}, 32'h1);
      tick();
      check("pri.rdy_high", {31'h0, bif.tx_rdy_o}, 32'h1);
      check("pri.done_count", done_cnt - d0, 1);

      // Timeout: send bit never clears
      d0 = done_cnt; e0 = err_cnt;
      bif.tx_req_i = 1'b1; bif.tx_byte_i = 8'h11;
      tick();
      bif.tx_req_i = 1'b0;
      tick();
      check_bus("to.data", 1'b1, 1'b1, 1'b0, 32'h11);
      tick();
      ctrl_reg = 32'h1;
      tick();
      for (int i = 0; i < 15; i++) tick();
      check("to.no_err_at_16", {31'h0, bif.tx_err_o}, 32'h0);
      check_bus("to.still_wait", 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      check("to.err_pulse", {31'h0, bif.tx_err_o}, 32'h1);
      check("to.rdy_low", {31'h0, bif.tx_rdy_o}, 32'h0);
      ctrl_reg = 32'h0;
      tick();
      check("to.err_end", {31'h0, bif.tx_err_o}, 32'h0);
      check("to.rdy_high", {31'h0, bif.tx_rdy_o}, 32'h1);
      check("to.err_count", err_cnt - e0, 1);
      check("to.done_count", done_cnt - d0, 0);

      // Reset while waiting; a second request during busy is ignored
      d0 = done_cnt; e0 = err_cnt; v0 = valid_cnt;
      bif.tx_req_i = 1'b1; bif.tx_byte_i = 8'hAA;
      tick();
      bif.tx_byte_i = 8'h77;
      tick();
      check_bus("rw.data", 1'b1, 1'b1, 1'b0, 32'hAA);
      tick();
      ctrl_reg = 32'h1;
      tick();
      bif.tx_req_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_reset_outputs("rw.async");
      tick();
      ctrl_reg = 32'h0;
      rst = 1'b1;
      tick();
      check_bus("rw.idle1", 1'b0, 1'b0, 1'b0, 32'h0);
      check("rw.rdy", {31'h0, bif.tx_rdy_o}, 32'h1);
      tick();
      check_bus("rw.idle2", 1'b0, 1'b0, 1'b0, 32'h0);
      check("rw.no_done", done_cnt - d0, 0);
      check("rw.no_err", err_cnt - e0, 0);
      check("rw.no_valid", valid_cnt - v0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
      $finish;
   end
endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 200000, max cycles spent in TX_WAIT before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tx_req_i  input  1  user requests a byte transmit.
REQ-005 SHALL have port tx_byte_i  input  8  byte to transmit, sampled on accept.
REQ-006 SHALL have port tx_rdy_o  output  1  high when no transmit is pending or in progress.
REQ-007 SHALL have port tx_done_o  output  1  one-cycle pulse, transmit completed.
REQ-008 SHALL have port tx_err_o  output  1  one-cycle pulse, transmit timed out.
REQ-009 SHALL have port rx_valid_o  output  1  one-cycle pulse, new byte on rx_byte_o.
REQ-010 SHALL have port rx_byte_o  output  8  last received byte, held until next receive.
REQ-011 SHALL have port wr_o  output  1  bus write strobe to peripheral.
REQ-012 SHALL have port reg_sel_o  output  1  0 = control register, 1 = data register.
REQ-013 SHALL have port addr_o  output  1  data register index: 0 = TX byte, 1 = RX byte.
REQ-014 SHALL have port wdata_o  output  32  bus write data.
REQ-015 SHALL have port rdata_i  input  32  bus read data, combinational from current reg_sel_o/addr_o.

Function
REQ-016 Control register bit0 = send (set by master, cleared by peripheral when byte sent); bit1 = new_rx (set by peripheral, cleared by master); bits 31:2 written 0.
REQ-017 Bus outputs SHALL be Moore-decoded from state; reads need no strobe; rdata_i sampled same cycle.
REQ-018 States: IDLE, RX_READ, RX_CLR, TX_DATA, TX_CTRL, TX_WAIT.
REQ-019 IDLE: wr_o=0, reg_sel_o=0, addr_o=0, wdata_o=0 (polls control each cycle).
REQ-020 IDLE -> RX_READ when rdata_i[1]=1; else -> TX_DATA when pending=1 and rdata_i[0]=0; else stay.
REQ-021 Receive SHALL have priority over transmit when both eligible in same cycle.
REQ-022 RX_READ: reg_sel_o=1, addr_o=1, wr_o=0; capture rdata_i[7:0] into rx_byte_o; -> RX_CLR.
REQ-023 RX_CLR: wr_o=1, reg_sel_o=0, wdata_o=32'h0; rx_valid_o pulses this cycle; -> IDLE.
REQ-024 TX_DATA: wr_o=1, reg_sel_o=1, addr_o=0, wdata_o={24'h0, pending byte}; -> TX_CTRL.
REQ-025 TX_CTRL: wr_o=1, reg_sel_o=0, wdata_o=32'h1; clear timeout counter; -> TX_WAIT.
REQ-026 TX_WAIT: bus as IDLE; rdata_i[0]=0 -> tx_done_o pulse, pending cleared, -> IDLE; new_rx not serviced until return to IDLE.
REQ-027 TX_WAIT counter increments each cycle; reaching TIMEOUT_CYC-1 with bit0 still 1 -> tx_err_o pulse, pending cleared, -> IDLE.
REQ-028 Accept occurs when tx_req_i=1 and tx_rdy_o=1: latch tx_byte_i, set pending; tx_rdy_o=0 from next cycle.
REQ-029 tx_rdy_o SHALL be registered, =1 only when pending=0; rises the cycle after tx_done_o or tx_err_o.
REQ-030 tx_req_i while tx_rdy_o=0 SHALL be ignored (no queueing).
REQ-031 Timeout counter SHALL be wide enough for TIMEOUT_CYC and saturate, never wrap.

Reset
REQ-032 On rst=0: state IDLE, pending=0, counter=0, tx_rdy_o=1, tx_done_o=0, tx_err_o=0, rx_valid_o=0, rx_byte_o=8'h00, wr_o=0, reg_sel_o=0, addr_o=0, wdata_o=0.
REQ-033 Reset asserted mid-transaction SHALL abandon it with no done/err/valid pulse; any held byte discarded.

Verification
REQ-034 Tx: rdata_i=0, tx_req_i=1 with 8'hA5 -> writes data addr0 = 32'hA5, then control = 32'h1; model clears bit0 after 10 cycles -> one tx_done_o, tx_rdy_o=1 next cycle.
REQ-035 Rx: control reads 32'h2, data addr1 reads 32'h3C -> rx_byte_o=8'h3C, rx_valid_o one pulse, control written 32'h0.
REQ-036 Priority: tx pending and control reads 32'h2 -> RX_READ/RX_CLR first, then TX_DATA.
REQ-037 Timeout: TIMEOUT_CYC=16, bit0 held 1 -> tx_err_o after 16 TX_WAIT cycles, no tx_done_o, tx_rdy_o=1.
REQ-038 Reset in TX_WAIT: rst=0 one cycle -> all outputs at reset values, no pulses; second tx_req_i during busy ignored.
